// File: rtl/counter_share_arbiter_if.sv
// Bundle between the timing clients and the shared interval counter.
// Latency: none, wires only.
// Backpressure: none; clients hold req high until their done pulse, or drop it to abort.
//
// Signals:
//   tick  client -> arbiter  count enable
//   req   client -> arbiter  level request per requester
//   dur   client -> arbiter  per-requester duration, slice i = dur[i*WIDTH +: WIDTH]
//   grant arbiter -> client  one-hot owner, zero when idle
//   done  arbiter -> client  one-cycle completion pulse to the owner
//   busy  arbiter -> client  arbiter is not idle
//   count arbiter -> client  current counter value
interface counter_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic                   tick;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] dur;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [WIDTH-1:0]       count;

    modport master (
        output tick, req, dur,
        input  grant, done, busy, count
    );

    modport slave (
        input  tick, req, dur,
        output grant, done, busy, count
    );
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin sharing of one up-counting interval timer between N_REQ requesters.
// Latency: grant one cycle after req; done one cycle after the final tick, for dur+1 ticks.
// Backpressure: count holds on tick=0; dropping the owner's req aborts with no done pulse.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset; outputs clear immediately
//   bus   counter_share_arbiter_if.slave: tick/req/dur in, grant/done/busy/count out
module counter_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_share_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q,   ptr_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic [WIDTH-1:0] dur_a [N_REQ];
    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    owner_nxt;
    logic [N_REQ-1:0] owner_oh;

    for (genvar g = 0; g < N_REQ; g++) begin : g_dur
        assign dur_a[g] = bus.dur[g*WIDTH +: WIDTH];
    end

    // Cyclic search starting at ptr. Walking the offsets from the far end
    // down to zero lets the nearest asserted requester overwrite the rest.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (int'(ptr_q) + k >= N_REQ) begin
                cand = IW'(int'(ptr_q) + k - N_REQ);
            end else begin
                cand = IW'(int'(ptr_q) + k);
            end
            if (bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Round-robin pointer moves past whoever just released the counter.
    assign owner_nxt = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        limit_d = limit_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = RUN;
                    owner_d = pick_idx;
                    limit_d = dur_a[pick_idx];
                    count_d = '0;
                end
            end
            RUN: begin
                // Abort wins over tick; the interval is dropped without done.
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = owner_nxt;
                end else if (bus.tick) begin
                    // Comparing before incrementing keeps count <= limit, so
                    // dur = all-ones never wraps.
                    if (count_q >= limit_q) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // req is not looked at here, so the owner cannot be re-granted
                // before the pointer has moved on.
                state_d = IDLE;
                ptr_d   = owner_nxt;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            limit_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            limit_q <= limit_d;
            count_q <= count_d;
        end
    end

    // Outputs come straight from registers so an async reset clears them at once.
    assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign bus.grant = (state_q != IDLE) ? owner_oh : '0;
    assign bus.done  = (state_q == DONE) ? owner_oh : '0;
    assign bus.busy  = (state_q != IDLE);
    assign bus.count = count_q;
endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an interval-level reference model.
// The model tracks owner, ticks consumed and the round-robin pointer in plain integers.
module tb_counter_share_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

    counter_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Reference model: phase 0 = no owner, 1 = interval running, 2 = done cycle.
    int m_phase, m_owner, m_lim, m_ticks, m_count, m_ptr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int dur_of(input int i);
        return int'((bus.dur >> (i * W)) & 32'hFF);
    endfunction

    function automatic bit req_of(input int i);
        return ((bus.req >> i) & 4'd1) != 4'd0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_lim = 0; m_ticks = 0; m_count = 0; m_ptr = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs held over the cycle.
    task automatic model_step();
        bit found;
        int idx;
        if (!rst) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && req_of(idx)) begin
                        found   = 1'b1;
                        m_owner = idx;
                    end
                end
                if (found) begin
                    m_phase = 1; m_lim = dur_of(m_owner); m_ticks = 0; m_count = 0;
                end
            end
            1: begin
                if (!req_of(m_owner)) begin
                    m_phase = 0;
                    m_ptr   = (m_owner + 1) % N;
                end else if (bus.tick) begin
                    // An interval consumes lim+1 ticks; the counter shows ticks so far, capped at lim.
                    m_ticks++;
                    m_count = (m_ticks > m_lim) ? m_lim : m_ticks;
                    if (m_ticks > m_lim) m_phase = 2;
                end
            end
            default: begin
                m_phase = 0;
                m_ptr   = (m_owner + 1) % N;
            end
        endcase
    endtask

    function automatic logic [31:0] exp_grant();
        return (m_phase != 0) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_done();
        return (m_phase == 2) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant", 32'(bus.grant), exp_grant());
            chk("done", 32'(bus.done), exp_done());
            chk("busy", 32'(bus.busy), 32'(m_phase != 0));
            chk("count", 32'(bus.count), 32'(m_count));
            chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
            chk("done_in_grant", 32'((bus.done & ~bus.grant) == 4'd0), 32'd1);
        end
    end

    // Advance one cycle: model takes the edge, then return at the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string nm);
        int n;
        n = 0;
        while (bus.grant != 4'd0 && n < 300) begin step(); n++; end
        while (bus.grant == 4'd0 && n < 300) begin step(); n++; end
        chk(nm, 32'(bus.grant), 32'(exp));
    endtask

    task automatic wait_count(input int val, input string nm);
        int n;
        n = 0;
        while (int'(bus.count) != val && n < 300) begin step(); n++; end
        chk(nm, 32'(bus.count), 32'(val));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int ticks, n, prev;
        bit wrapped;
        logic [3:0] r;

        bus.tick = 1'b0;
        bus.req  = '0;
        bus.dur  = '0;
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_en = 1'b1;
        step();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        rst = 1'b1;
        step();

        // 1: single requester, dur0=3, tick always high
        bus.dur = {8'd0, 8'd0, 8'd0, 8'd3};
        bus.tick = 1'b1;
        bus.req = 4'b0001;
        step();
        chk("t1_grant", 32'(bus.grant), 32'd1);
        chk("t1_count0", 32'(bus.count), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("t1_count", 32'(bus.count), 32'(c));
            chk("t1_no_done_yet", 32'(bus.done), 32'd0);
        end
        step();
        chk("t1_done", 32'(bus.done), 32'd1);
        bus.req = 4'b0000;
        step();
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);

        // Bring ptr back to 0: grant ch3, then abort it.
        bus.req = 4'b1000;
        wait_grant(4'b1000, "t2_pre_ch3");
        bus.req = 4'b0000;
        step();

        // 2: round-robin order
        bus.dur = '0;
        bus.req = 4'b0101;
        wait_grant(4'b0001, "t2_ch0_first");
        wait_grant(4'b0100, "t2_ch2_second");
        bus.req = 4'b1111;
        wait_grant(4'b1000, "t2_all_ch3");
        wait_grant(4'b0001, "t2_all_ch0");
        wait_grant(4'b0010, "t2_all_ch1");
        wait_grant(4'b0100, "t2_all_ch2");
        bus.req = 4'b0000;
        step();

        // 3: toggling tick, dur1=2, dur changed to 9 mid-interval
        bus.dur = {8'd0, 8'd0, 8'd2, 8'd0};
        bus.tick = 1'b0;
        bus.req = 4'b0010;
        wait_grant(4'b0010, "t3_grant");
        bus.dur = {8'd0, 8'd0, 8'd9, 8'd0};
        ticks = 0;
        n = 0;
        while (bus.done == 4'd0 && n < 40) begin
            bus.tick = ~bus.tick;
            if (bus.tick) ticks++;
            step();
            n++;
        end
        chk("t3_done", 32'(bus.done), 32'd2);
        chk("t3_ticks", 32'(ticks), 32'd3);
        chk("t3_final_count", 32'(bus.count), 32'd2);
        bus.tick = 1'b1;
        bus.req = 4'b0000;
        step();

        // 4: abort ch3 at count 4, pending ch0 follows
        bus.dur = {8'd10, 8'd0, 8'd0, 8'd20};
        bus.req = 4'b1001;
        wait_grant(4'b1000, "t4_grant_ch3");
        wait_count(4, "t4_count4");
        bus.req = 4'b0001;
        step();
        chk("t4_abort_grant", 32'(bus.grant), 32'd0);
        chk("t4_abort_done", 32'(bus.done), 32'd0);
        step();
        chk("t4_next_ch0", 32'(bus.grant), 32'd1);

        // 5: async reset in RUN at count 5
        wait_count(5, "t5_count5");
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_grant", 32'(bus.grant), 32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_count", 32'(bus.count), 32'd0);
        bus.req = 4'b1111;
        @(negedge clk);
        #2 rst = 1'b1;
        step();
        chk("t5_after_rst_ch0", 32'(bus.grant), 32'd1);
        bus.req = 4'b0000;
        step();

        // 6: dur=255, no wrap
        bus.dur = {8'd0, 8'd255, 8'd0, 8'd0};
        bus.req = 4'b0100;
        wait_grant(4'b0100, "t6_grant");
        n = 0;
        prev = 0;
        wrapped = 1'b0;
        while (bus.done == 4'd0 && n < 400) begin
            if (int'(bus.count) < prev) wrapped = 1'b1;
            prev = int'(bus.count);
            step();
            n++;
        end
        chk("t6_cycles_to_done", 32'(n), 32'd256);
        chk("t6_done_count", 32'(bus.count), 32'd255);
        chk("t6_no_wrap", 32'(wrapped), 32'd0);
        bus.req = 4'b0000;
        step();
        step();
        chk("t6_idle_count", 32'(bus.count), 32'd255);
        chk("t6_idle_busy", 32'(bus.busy), 32'd0);

        // Randomized traffic with occasional async reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = bus.req;
            for (int i = 0; i < N; i++) begin
                if (r[i]) r[i] = ($urandom_range(0, 31) != 0);
                else      r[i] = ($urandom_range(0, 3) == 0);
            end
            bus.req = r;
            for (int i = 0; i < N; i++) begin
                bus.dur[i*W +: W] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40))
                                                                 : 8'($urandom_range(0, 6));
            end
            bus.tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                @(negedge clk);
                #2 rst = 1'b1;
            end
            step();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
